// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, ALU operand select and load-use stall generation.
// Build option ID_EX_FORWARD_EN: when defined, forward from EX/MEM and MEM/WB; otherwise stall on RAW hazards.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_alu_control,
    input  logic          id_alu_src,
    input  logic          id_is_shift,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          flush,
    input  logic          ex_hold,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_control,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          stall
);

    logic [RW-1:0] rs_q, rt_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic [4:0]    shamt_q;
    logic          alu_src_q, is_shift_q;
    logic [DW-1:0] fa, fb;
    logic          haz, raw_haz, bubble;

    assign haz = ex_valid & ex_mem_read & (ex_dest != '0)
               & ((ex_dest == id_rs) | (ex_dest == id_rt)) & id_valid;

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger producer, so it is checked first.
    assign fa = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q) ? exmem_result :
                (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q) ? memwb_result :
                rs_data_q;
    assign fb = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q) ? exmem_result :
                (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q) ? memwb_result :
                rt_data_q;
    assign raw_haz = 1'b0;
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, rs_q, rt_q};

    assign fa = rs_data_q;
    assign fb = rt_data_q;
    // Without forwarding, wait until the producer reaches MEM/WB (register file covers that stage).
    assign raw_haz =
        ((id_rs != '0) && ((ex_valid && ex_reg_write && ex_dest == id_rs) ||
                           (exmem_reg_write && exmem_rd == id_rs))) ||
        ((id_rt != '0) && ((ex_valid && ex_reg_write && ex_dest == id_rt) ||
                           (exmem_reg_write && exmem_rd == id_rt)));
`endif

    assign bubble        = haz | raw_haz;
    assign stall         = bubble | ex_hold;
    assign alu_a         = is_shift_q ? fb : fa;
    assign alu_b         = is_shift_q ? {{(DW-5){1'b0}}, shamt_q} : (alu_src_q ? imm_q : fb);
    assign ex_store_data = fb;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || (!ex_hold && (flush || bubble))) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            alu_control   <= '0;
            ex_dest       <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            alu_src_q     <= 1'b0;
            is_shift_q    <= 1'b0;
        end else if (!ex_hold) begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_reg_write & id_valid;
            ex_mem_read   <= id_mem_read & id_valid;
            ex_mem_write  <= id_mem_write & id_valid;
            ex_mem_to_reg <= id_mem_to_reg & id_valid;
            alu_control   <= id_alu_control;
            ex_dest       <= id_reg_dst ? id_rd : id_rt;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            rs_data_q     <= id_rs_data;
            rt_data_q     <= id_rt_data;
            imm_q         <= id_imm;
            shamt_q       <= id_shamt;
            alu_src_q     <= id_alu_src;
            is_shift_q    <= id_is_shift;
        end
    end

endmodule
